// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Imported by the top level, the hold register and the bench.
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_hold_reg.sv
// Output register for the fetched instruction word, its PC and fault flag.
// Loads on load_en; a synchronous reset restores the NOP word with PC 0.
module ifetch_hold_reg
  import ifetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [XLEN-1:0] data_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            fault_in,
  output logic [XLEN-1:0] data_q,
  output logic [XLEN-1:0] pc_q,
  output logic            fault_q
);

  logic [XLEN-1:0] data_d;
  logic [XLEN-1:0] pc_d;
  logic            fault_d;

  always_comb begin
    data_d  = data_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (load_en) begin
      data_d  = data_in;
      pc_d    = pc_in;
      fault_d = fault_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= NOP_INST;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: one outstanding imem request at a time, holds the
// returned word for decode and stalls the PC until it is consumed or redirected.
module ifetch_stage
  import ifetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_addr,
  input  logic            flush,
  output logic            pc_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  ifetch_state_t   state_q, state_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic            load_en;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] load_pc;
  logic            load_fault;
  logic            misaligned;

  assign misaligned = (pc_addr[1:0] != 2'b00);

  // imem_addr simply mirrors the PC; pc_stall keeps it stable across grant stalls.
  assign imem_addr  = pc_addr;
  assign imem_req   = (state_q == IDLE) && !rst && !flush && !misaligned;
  assign inst_valid = (state_q == HOLD) && !flush;
  assign pc_stall   = rst || !(flush || ((state_q == HOLD) && inst_ready));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    req_pc_d   = req_pc_q;
    load_en    = 1'b0;
    load_data  = imem_rdata;
    load_pc    = req_pc_q;
    load_fault = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!flush) begin
          if (misaligned) begin
            load_en    = 1'b1;
            load_data  = NOP_INST;
            load_pc    = pc_addr;
            load_fault = 1'b1;
            state_d    = HOLD;
          end else if (imem_gnt) begin
            req_pc_d = pc_addr;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || flush) begin
            kill_d  = 1'b0;
            state_d = IDLE;
          end else begin
            load_en = 1'b1;
            state_d = HOLD;
          end
        end else if (flush) begin
          // The response is still owed by memory; remember to discard it.
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (flush || inst_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      kill_q   <= 1'b0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      req_pc_q <= req_pc_d;
    end
  end

  ifetch_hold_reg u_hold_reg (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .data_in  (load_data),
    .pc_in    (load_pc),
    .fault_in (load_fault),
    .data_q   (inst_data),
    .pc_q     (inst_pc),
    .fault_q  (inst_fault)
  );

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: inputs change on the falling edge and
// outputs are compared 1ns later, well away from the rising edge.
module tb_ifetch_stage;
  import ifetch_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_addr;
  logic            flush;
  logic            pc_stall;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ifetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .flush       (flush),
    .pc_stall    (pc_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_fault  (inst_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then settle before checks.
  task automatic cyc(input logic r, input logic [31:0] pc, input logic fl,
                     input logic g, input logic rv, input logic [31:0] rd, input logic rdy);
    @(negedge clk);
    rst         = r;
    pc_addr     = pc;
    flush       = fl;
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    inst_ready  = rdy;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, 32'(inst_valid), 32'd0);
    check({tag, ".data"},  inst_data,       NOP_INST);
    check({tag, ".pc"},    inst_pc,         32'd0);
    check({tag, ".fault"}, 32'(inst_fault), 32'd0);
  endtask

  initial begin
    rst = 1'b1; pc_addr = '0; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;

    // Reset
    cyc(1, 32'h0, 0, 0, 0, 32'h0, 0);
    check("rst.stall", 32'(pc_stall), 32'd1);
    check("rst.req",   32'(imem_req), 32'd0);
    cyc(1, 32'h0, 0, 0, 0, 32'h0, 0);
    check_reset_outputs("rst");

    // Best case: grant, rvalid, valid+ready in cycle 2
    cyc(0, 32'h0, 0, 1, 0, 32'h0, 0);
    check("t1.c0.req",   32'(imem_req), 32'd1);
    check("t1.c0.addr",  imem_addr,     32'h0);
    check("t1.c0.stall", 32'(pc_stall), 32'd1);
    cyc(0, 32'h0, 0, 0, 1, 32'h0050_0093, 1);
    check("t1.c1.req",   32'(imem_req),   32'd0);
    check("t1.c1.valid", 32'(inst_valid), 32'd0);
    check("t1.c1.stall", 32'(pc_stall),   32'd1);
    cyc(0, 32'h0, 0, 0, 0, 32'h0, 1);
    check("t1.c2.valid", 32'(inst_valid), 32'd1);
    check("t1.c2.data",  inst_data,       32'h0050_0093);
    check("t1.c2.pc",    inst_pc,         32'h0);
    check("t1.c2.fault", 32'(inst_fault), 32'd0);
    check("t1.c2.stall", 32'(pc_stall),   32'd0);

    // Grant delayed 3 cycles, decode stalls 4 cycles
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'h4, 0, 0, 0, 32'h0, 0);
      check("t2.gw.req",   32'(imem_req), 32'd1);
      check("t2.gw.addr",  imem_addr,     32'h4);
      check("t2.gw.stall", 32'(pc_stall), 32'd1);
    end
    cyc(0, 32'h4, 0, 1, 0, 32'h0, 0);
    check("t2.gnt.addr", imem_addr, 32'h4);
    cyc(0, 32'h4, 0, 0, 1, 32'h00A0_0113, 0);
    check("t2.rv.stall", 32'(pc_stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 32'h4, 0, 0, 0, 32'h0, 0);
      check("t2.hold.valid", 32'(inst_valid), 32'd1);
      check("t2.hold.data",  inst_data,       32'h00A0_0113);
      check("t2.hold.pc",    inst_pc,         32'h4);
      check("t2.hold.stall", 32'(pc_stall),   32'd1);
      check("t2.hold.req",   32'(imem_req),   32'd0);
    end
    cyc(0, 32'h4, 0, 0, 0, 32'h0, 1);
    check("t2.acc.stall", 32'(pc_stall), 32'd0);

    // Misaligned PC: fault with no memory access
    cyc(0, 32'h6, 0, 1, 0, 32'h0, 0);
    check("t3.req",   32'(imem_req), 32'd0);
    check("t3.stall", 32'(pc_stall), 32'd1);
    cyc(0, 32'h6, 0, 0, 0, 32'h0, 1);
    check("t3.valid", 32'(inst_valid), 32'd1);
    check("t3.fault", 32'(inst_fault), 32'd1);
    check("t3.data",  inst_data,       32'h0000_0013);
    check("t3.pc",    inst_pc,         32'h6);
    check("t3.stall", 32'(pc_stall),   32'd0);

    // Flush in WAIT; late response is dropped, next fetch uses new PC
    cyc(0, 32'h8, 0, 1, 0, 32'h0, 0);
    check("t4.req", 32'(imem_req), 32'd1);
    cyc(0, 32'h8, 1, 0, 0, 32'h0, 1);
    check("t4.fl.stall", 32'(pc_stall),   32'd0);
    check("t4.fl.valid", 32'(inst_valid), 32'd0);
    cyc(0, 32'h100, 0, 1, 0, 32'h0, 1);
    check("t4.w.req",   32'(imem_req), 32'd0);
    check("t4.w.stall", 32'(pc_stall), 32'd1);
    cyc(0, 32'h100, 0, 0, 1, 32'h0000_0BAD, 1);
    check("t4.rv.valid", 32'(inst_valid), 32'd0);
    cyc(0, 32'h100, 0, 1, 0, 32'h0, 0);
    check("t4.drop.valid", 32'(inst_valid), 32'd0);
    check("t4.new.req",    32'(imem_req),   32'd1);
    check("t4.new.addr",   imem_addr,       32'h100);
    cyc(0, 32'h100, 0, 0, 1, 32'h0000_0193, 0);
    cyc(0, 32'h100, 0, 0, 0, 32'h0, 0);
    check("t4.new.valid", 32'(inst_valid), 32'd1);
    check("t4.new.data",  inst_data,       32'h0000_0193);
    check("t4.new.pc",    inst_pc,         32'h100);

    // Flush and ready together in HOLD: one PC move, back to IDLE
    cyc(0, 32'h100, 1, 0, 0, 32'h0, 1);
    check("t5.valid", 32'(inst_valid), 32'd0);
    check("t5.stall", 32'(pc_stall),   32'd0);
    cyc(0, 32'h200, 0, 0, 0, 32'h0, 1);
    check("t5.idle.valid", 32'(inst_valid), 32'd0);
    check("t5.idle.req",   32'(imem_req),   32'd1);
    check("t5.idle.stall", 32'(pc_stall),   32'd1);

    // Reset while in WAIT
    cyc(0, 32'h200, 0, 1, 0, 32'h0, 0);
    cyc(1, 32'h200, 0, 0, 0, 32'h0, 0);
    check("t6.rst.stall", 32'(pc_stall), 32'd1);
    check("t6.rst.req",   32'(imem_req), 32'd0);
    cyc(0, 32'h200, 0, 0, 0, 32'h0, 0);
    check_reset_outputs("t6");
    check("t6.state", 32'(dut.state_q), 32'(IDLE));
    check("t6.kill",  32'(dut.kill_q),  32'd0);
    check("t6.req",   32'(imem_req),    32'd1);
    check("t6.stall", 32'(pc_stall),    32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
